branch_predictor_btb: RTL and testbench

Direct-mapped branch target buffer with a 2-bit saturating counter per entry. It implements the predictor side of the branch predictor/pipeline interface. Fetch presents `current_pc` and receives `predict_taken`/`target_addr` in the same cycle. The execute stage writes resolved branch outcomes back through the update port. The block also keeps lookup/mispredict performance counters for the pipeline's CSR/statistics logic.

---
 rtl/branch_predictor_btb.sv | 133 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup is combinational; resolved branches update the table and stats counters on CLK.
module branch_predictor_btb #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] current_pc,
    output logic        predict_taken,
    output logic [31:0] target_addr,
    input  logic        update_predictor,
    input  logic [31:0] update_addr,
    input  logic [31:0] update_target,
    input  logic        prediction,
    input  logic        branch_result,
    output logic [31:0] update_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        update_count_q, update_count_d;
    logic [31:0]        mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0]     lk_idx_s;
    logic [TAG_W-1:0]   lk_tag_s;
    logic               lk_hit_s;
    logic [IDX-1:0]     up_idx_s;
    logic [TAG_W-1:0]   up_tag_s;
    logic               up_hit_s;
    logic               unused_pc_bits_s;

    // The low two PC bits never select an entry; fold them away explicitly.
    assign unused_pc_bits_s = ^{current_pc[1:0], update_addr[1:0]};

    // Fetch-side lookup reads the registered table, so it always sees pre-update contents.
    always_comb begin
        lk_idx_s      = current_pc[IDX+1:2];
        lk_tag_s      = current_pc[31:IDX+2];
        lk_hit_s      = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        predict_taken = lk_hit_s && ctr_q[lk_idx_s][1];
        if (lk_hit_s) begin
            target_addr = target_q[lk_idx_s];
        end else begin
            target_addr = 32'd0;
        end
    end

    // Next-state for the table and statistics from the resolved-branch port.
    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        ctr_d              = ctr_q;
        update_count_d     = update_count_q;
        mispredict_count_d = mispredict_count_q;
        up_idx_s           = update_addr[IDX+1:2];
        up_tag_s           = update_addr[31:IDX+2];
        up_hit_s           = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
        if (update_predictor) begin
            update_count_d = update_count_q + 32'd1;
            if (prediction != branch_result) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
            case ({up_hit_s, branch_result})
                2'b11: begin
                    ctr_d[up_idx_s]    = ctr_inc(ctr_q[up_idx_s]);
                    target_d[up_idx_s] = update_target;
                end
                2'b10: begin
                    ctr_d[up_idx_s] = ctr_dec(ctr_q[up_idx_s]);
                end
                // A taken miss replaces the slot outright, dropping any previous history.
                2'b01: begin
                    valid_d[up_idx_s]  = 1'b1;
                    tag_d[up_idx_s]    = up_tag_s;
                    target_d[up_idx_s] = update_target;
                    ctr_d[up_idx_s]    = 2'b10;
                end
                default: begin
                    ctr_d[up_idx_s] = ctr_q[up_idx_s];
                end
            endcase
        end else begin
            update_count_d = update_count_q;
        end
    end

    // State registers; reset wins over any concurrent update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q            <= '0;
            update_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q            <= valid_d;
            update_count_q     <= update_count_d;
            mispredict_count_q <= mispredict_count_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    assign update_count     = update_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: expected lookup/stat values are queued
// when a cycle is driven and popped when the outputs are sampled mid-cycle.
module tb_branch_predictor_btb;

    logic        CLK;
    logic        RST;
    logic [31:0] current_pc;
    logic        predict_taken;
    logic [31:0] target_addr;
    logic        update_predictor;
    logic [31:0] update_addr;
    logic [31:0] update_target;
    logic        prediction;
    logic        branch_result;
    logic [31:0] update_count;
    logic [31:0] mispredict_count;

    int          vec_cnt;
    int          err_cnt;
    int          cyc_no;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    branch_predictor_btb #(.ENTRIES(16)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .current_pc       (current_pc),
        .predict_taken    (predict_taken),
        .target_addr      (target_addr),
        .update_predictor (update_predictor),
        .update_addr      (update_addr),
        .update_target    (update_target),
        .prediction       (prediction),
        .branch_result    (branch_result),
        .update_count     (update_count),
        .mispredict_count (mispredict_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue what the outputs must show before the edge, then score them.
    task automatic cyc(input logic rst, input logic [31:0] pc, input logic upd,
                       input logic [31:0] addr, input logic [31:0] tgt,
                       input logic pred, input logic res,
                       input logic e_taken, input logic [31:0] e_tgt,
                       input logic [31:0] e_uc, input logic [31:0] e_mc);
        RST              = rst;
        current_pc       = pc;
        update_predictor = upd;
        update_addr      = addr;
        update_target    = tgt;
        prediction       = pred;
        branch_result    = res;
        cyc_no++;
        tag_q.push_back($sformatf("c%0d_taken", cyc_no));  exp_q.push_back({31'd0, e_taken});
        tag_q.push_back($sformatf("c%0d_target", cyc_no)); exp_q.push_back(e_tgt);
        tag_q.push_back($sformatf("c%0d_upd_cnt", cyc_no)); exp_q.push_back(e_uc);
        tag_q.push_back($sformatf("c%0d_mis_cnt", cyc_no)); exp_q.push_back(e_mc);
        #1;
        check_val(tag_q.pop_front(), {31'd0, predict_taken}, exp_q.pop_front());
        check_val(tag_q.pop_front(), target_addr, exp_q.pop_front());
        check_val(tag_q.pop_front(), update_count, exp_q.pop_front());
        check_val(tag_q.pop_front(), mispredict_count, exp_q.pop_front());
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        cyc_no  = 0;
        RST = 1'b1; current_pc = 32'h100; update_predictor = 1'b0;
        update_addr = 32'd0; update_target = 32'd0; prediction = 1'b0; branch_result = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        //   rst   pc        upd   addr      tgt       pred  res   e_tk  e_tgt     e_uc   e_mc
        // Reset state, then allocate 0x100 -> 0x200 (mispredicted)
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0, 32'h000, 32'd0, 32'd0);
        // Hysteresis: 10 -> 01 -> 00 -> 00 (saturate) -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h999, 1'b1, 1'b0, 1'b1, 32'h200, 32'd1, 32'd1);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h999, 1'b0, 1'b0, 1'b0, 32'h200, 32'd2, 32'd2);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h999, 1'b0, 1'b0, 1'b0, 32'h200, 32'd3, 32'd2);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0, 32'h200, 32'd4, 32'd2);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h204, 1'b0, 1'b1, 1'b0, 32'h200, 32'd5, 32'd3);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h204, 1'b1, 1'b1, 1'b1, 32'h204, 32'd6, 32'd4);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h204, 1'b1, 1'b1, 1'b1, 32'h204, 32'd7, 32'd4);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h999, 1'b1, 1'b0, 1'b1, 32'h204, 32'd8, 32'd4);
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h999, 1'b1, 1'b0, 1'b1, 32'h204, 32'd9, 32'd5);
        // Aliasing: 0x140 shares index 0; not-taken miss changes nothing
        cyc(1'b0, 32'h140, 1'b1, 32'h140, 32'h300, 1'b0, 1'b0, 1'b0, 32'h000, 32'd10, 32'd6);
        cyc(1'b0, 32'h100, 1'b1, 32'h140, 32'h300, 1'b0, 1'b1, 1'b0, 32'h204, 32'd11, 32'd6);
        cyc(1'b0, 32'h140, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b1, 32'h300, 32'd12, 32'd7);
        cyc(1'b0, 32'h100, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 32'd12, 32'd7);
        // Same-cycle lookup and update of 0x180 sees pre-update contents
        cyc(1'b0, 32'h180, 1'b1, 32'h180, 32'h400, 1'b0, 1'b1, 1'b0, 32'h000, 32'd12, 32'd7);
        cyc(1'b0, 32'h180, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b1, 32'h400, 32'd13, 32'd8);
        // Reset together with an update: update dropped, everything cleared
        cyc(1'b1, 32'h104, 1'b1, 32'h104, 32'h500, 1'b0, 1'b1, 1'b0, 32'h000, 32'd13, 32'd8);
        cyc(1'b0, 32'h104, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 32'd0, 32'd0);
        cyc(1'b0, 32'h180, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 32'd0, 32'd0);
        // Counter wrap from an all-ones preload
        force dut.update_count_q     = 32'hFFFF_FFFF;
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.update_count_q;
        release dut.mispredict_count_q;
        cyc(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 32'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(1'b0, 32'h100, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 32'd0, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
